// File: rtl/mat_result_writer.sv
// Multiply-accumulates DIM operand pairs per element and writes each result row-major into result RAM.
// Latency: write one cycle after the DIM-th pair of an element; in_ready drops for that write cycle only.
module mat_result_writer #(
  parameter  int DIM  = 3,
  parameter  int DW   = 8,
  parameter  int ACCW = 2*DW + $clog2(DIM) + 1,
  localparam int AW   = $clog2(DIM*DIM-1) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic            in_ready,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [ACCW-1:0] wr_data,
  output logic            busy,
  output logic            done
);

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WRITE, S_DONE} state_t;

  state_t          r_state;
  logic [ACCW-1:0] r_acc;
  logic [CW-1:0]   r_k;
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_in_ready;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [ACCW-1:0] r_wr_data;
  logic            r_busy;
  logic            r_done;

  logic            w_fire;
  logic [ACCW-1:0] w_prod;
  logic [ACCW-1:0] w_sum;
  logic            w_last_k;
  logic            w_last_col;
  logic            w_last_row;
  logic [AW-1:0]   w_addr;

  assign w_fire     = in_valid && r_in_ready;
  assign w_prod     = ACCW'(in_a) * ACCW'(in_b);
  assign w_sum      = r_acc + w_prod;
  assign w_last_k   = (r_k   == CW'(DIM-1));
  assign w_last_col = (r_col == CW'(DIM-1));
  assign w_last_row = (r_row == CW'(DIM-1));
  assign w_addr     = AW'(r_row) * AW'(DIM) + AW'(r_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_k        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_acc      <= '0;
            r_k        <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_fire) begin
            r_acc <= w_sum;
            if (w_last_k) begin
              // The write strobe is registered here so it lands exactly one cycle after the last pair.
              r_k        <= '0;
              r_in_ready <= 1'b0;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= w_addr;
              r_wr_data  <= w_sum;
              r_state    <= S_WRITE;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_acc <= '0;
          if (w_last_col) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
          if (w_last_row && w_last_col) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_mat_result_writer.sv
// Directed bench for mat_result_writer (DIM=3): checks write order, values, timing, reset and restart.
module tb_mat_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [18:0] wr_data;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_err = 0;

  int w_addr_q[$];
  int w_data_q[$];
  int w_cyc_q[$];
  int hs_q[$];

  mat_result_writer #(.DIM(3), .DW(8), .ACCW(19)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and writes mid-cycle, when inputs and registered outputs are both stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) hs_q.push_back(cyc);
      if (wr_en) begin
        w_addr_q.push_back(int'(wr_addr));
        w_data_q.push_back(int'(wr_data));
        w_cyc_q.push_back(cyc);
      end
      if (wr_en && (in_ready || !busy)) rdy_err++;
      if (busy && !wr_en && !in_ready) rdy_err++;
      if (done && (in_ready || busy)) rdy_err++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    w_addr_q.delete();
    w_data_q.delete();
    w_cyc_q.delete();
    hs_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // mode 0: all ones, mode 1: all 255, mode 2: A=I, B=[1..9] in read-side order
  function automatic logic [7:0] op_a(input int mode, input int i);
    int e = i / 3;
    int k = i % 3;
    case (mode)
      0: op_a = 8'd1;
      1: op_a = 8'd255;
      default: op_a = ((e / 3) == k) ? 8'd1 : 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] op_b(input int mode, input int i);
    int e = i / 3;
    int k = i % 3;
    case (mode)
      0: op_b = 8'd1;
      1: op_b = 8'd255;
      default: op_b = 8'(3 * k + (e % 3) + 1);
    endcase
  endfunction

  function automatic int exp_data(input int mode, input int e);
    case (mode)
      0: exp_data = 3;
      1: exp_data = 195075;
      default: exp_data = e + 1;
    endcase
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit gaps, input bit with_start);
    int t = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    start    = with_start;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    step();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_pairs(input int mode, input int n, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) send(op_a(mode, i), op_b(mode, i), gaps, i == start_at);
  endtask

  task automatic check_pass(input string tag, input int mode);
    chk({tag, "_nwr"}, 32'(w_addr_q.size()), 32'd9);
    chk({tag, "_nhs"}, 32'(hs_q.size()), 32'd27);
    for (int e = 0; e < 9 && e < w_addr_q.size(); e++) begin
      chk({tag, "_addr"}, 32'(w_addr_q[e]), 32'(e));
      chk({tag, "_data"}, 32'(w_data_q[e]), 32'(exp_data(mode, e)));
      if (hs_q.size() > 3 * e + 2)
        chk({tag, "_lat"}, 32'(w_cyc_q[e]), 32'(hs_q[3 * e + 2] + 1));
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"},  32'(in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    rst = 1'b0;

    // in_valid in IDLE must be ignored
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
    repeat (2) step();
    in_valid = 1'b0;
    chk("idle_rdy", 32'(in_ready), 32'd0);
    chk("idle_nwr", 32'(w_addr_q.size()), 32'd0);

    // All ones, back-to-back, with a start pulse during ACC
    clear_q();
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rdy",  32'(in_ready), 32'd1);
    run_pairs(0, 27, 1'b0, 10);
    repeat (2) step();
    check_pass("ones", 0);

    // Done holds, in_valid ignored in DONE
    in_valid = 1'b1;
    repeat (4) step();
    in_valid = 1'b0;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_nwr",  32'(w_addr_q.size()), 32'd9);

    // Restart from DONE repeats the same writes
    clear_q();
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    run_pairs(0, 27, 1'b0, -1);
    repeat (2) step();
    check_pass("ones2", 0);

    clear_q();
    pulse_start();
    run_pairs(1, 27, 1'b0, -1);
    repeat (2) step();
    check_pass("max", 1);

    clear_q();
    pulse_start();
    run_pairs(2, 27, 1'b0, -1);
    repeat (2) step();
    check_pass("ident", 2);

    clear_q();
    pulse_start();
    run_pairs(2, 27, 1'b1, -1);
    repeat (2) step();
    check_pass("gaps", 2);

    // Reset after 4 writes with a partial accumulation in flight
    clear_q();
    pulse_start();
    run_pairs(1, 13, 1'b0, -1);
    chk("mid_nwr", 32'(w_addr_q.size()), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rdy",  32'(in_ready), 32'd0);
    chk("mid_rst_wren", 32'(wr_en),    32'd0);
    chk("mid_rst_busy", 32'(busy),     32'd0);
    chk("mid_rst_done", 32'(done),     32'd0);
    chk("mid_rst_addr", 32'(wr_addr),  32'd0);
    chk("mid_rst_data", 32'(wr_data),  32'd0);
    step();
    chk("mid_idle_rdy", 32'(in_ready), 32'd0);
    clear_q();
    pulse_start();
    run_pairs(0, 27, 1'b0, -1);
    repeat (2) step();
    check_pass("after_rst", 0);

    chk("ready_rules", 32'(rdy_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
